// File: rtl/reg_file_param_pkg.sv
// regfile_pkg: shared state type, default geometry and address-range helper for reg_file_param
package regfile_pkg;

    typedef enum logic {CLEAR, READY} state_t;

    localparam int DEF_WIDTH  = 64;
    localparam int DEF_DEPTH  = 32;
    localparam int DEF_ADDR_W = 5;

    function automatic logic addr_valid(input int unsigned addr, input int unsigned depth);
        return addr < depth;
    endfunction

endpackage

// File: rtl/reg_file_param_rf_read_port.sv
// rf_read_port: registered read port with range/zero masking; write-first bypass when REGFILE_BYPASS_EN is defined
module rf_read_port
    import regfile_pkg::*;
#(
    parameter int WIDTH    = DEF_WIDTH,
    parameter int DEPTH    = DEF_DEPTH,
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int ZERO_REG = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              busy,
    input  logic              ren,
    input  logic [ADDR_W-1:0] raddr,
    input  logic [WIDTH-1:0]  word,
    input  logic              wr_ok,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [WIDTH-1:0]  wdata,
    output logic [WIDTH-1:0]  rdata
);

    logic             ok;
    logic [WIDTH-1:0] sel;

    assign ok = addr_valid(32'(raddr), DEPTH) && !(ZERO_REG != 0 && raddr == '0);

`ifdef REGFILE_BYPASS_EN
    assign sel = (wr_ok && waddr == raddr) ? wdata : word;
`else
    logic unused_wr;
    assign unused_wr = ^{wr_ok, waddr, wdata};
    assign sel = word;
`endif

    // capture masked data on enabled reads once the clear has finished
    always_ff @(posedge clk) begin
        if (reset) rdata <= '0;
        else if (!busy && ren) rdata <= ok ? sel : '0;
    end

endmodule

// File: rtl/reg_file_param.sv
// reg_file_param: 1W/2R register file with post-reset clear sequencer; define REGFILE_BYPASS_EN for write-first reads
module reg_file_param
    import regfile_pkg::*;
#(
    parameter int WIDTH    = DEF_WIDTH,
    parameter int DEPTH    = DEF_DEPTH,
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int ZERO_REG = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ren1,
    input  logic [ADDR_W-1:0] raddr1,
    output logic [WIDTH-1:0]  rdata1,
    input  logic              ren2,
    input  logic [ADDR_W-1:0] raddr2,
    output logic [WIDTH-1:0]  rdata2,
    input  logic              wen,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [WIDTH-1:0]  wdata,
    output logic              busy
);

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] clr_ptr, clr_nxt;
    logic              last, wr_ok;
    logic [WIDTH-1:0]  mem [DEPTH];

    assign busy  = state == CLEAR;
    assign last  = clr_ptr == ADDR_W'(DEPTH - 1);
    assign wr_ok = !reset && !busy && wen && addr_valid(32'(waddr), DEPTH) && !(ZERO_REG != 0 && waddr == '0);

    // clear sequencer: walk every entry once, then park in READY
    always_comb begin
        state_nxt = (busy && last) ? READY : state;
        clr_nxt   = (busy && !last) ? clr_ptr + 1'b1 : '0;
    end

    // sequencer state register; reset restarts the clear from entry 0
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= CLEAR;
            clr_ptr <= '0;
        end else begin
            state   <= state_nxt;
            clr_ptr <= clr_nxt;
        end
    end

    // storage: zeroed by the sequencer, otherwise written by the write port
    always_ff @(posedge clk) begin
        if (busy) mem[clr_ptr] <= '0;
        else if (wr_ok) mem[waddr] <= wdata;
    end

    rf_read_port #(.WIDTH(WIDTH), .DEPTH(DEPTH), .ADDR_W(ADDR_W), .ZERO_REG(ZERO_REG)) u_rd1 (
        .clk(clk), .reset(reset), .busy(busy), .ren(ren1), .raddr(raddr1), .word(mem[raddr1]),
        .wr_ok(wr_ok), .waddr(waddr), .wdata(wdata), .rdata(rdata1)
    );

    rf_read_port #(.WIDTH(WIDTH), .DEPTH(DEPTH), .ADDR_W(ADDR_W), .ZERO_REG(ZERO_REG)) u_rd2 (
        .clk(clk), .reset(reset), .busy(busy), .ren(ren2), .raddr(raddr2), .word(mem[raddr2]),
        .wr_ok(wr_ok), .waddr(waddr), .wdata(wdata), .rdata(rdata2)
    );

endmodule

// File: tb/tb_reg_file_param.sv
// tb_reg_file_param: three configurations (default, no zero register, DEPTH=20) checked against an array model every cycle
module tb_reg_file_param;

    localparam int DEP [3] = '{32, 32, 20};
    localparam int ZR  [3] = '{1, 0, 1};

    logic        clk = 0;
    logic        reset = 1;
    logic        ren1 = 0, ren2 = 0, wen = 0;
    logic [4:0]  raddr1 = 0, raddr2 = 0, waddr = 0;
    logic [63:0] wdata = 0;
    logic [63:0] rd1 [3];
    logic [63:0] rd2 [3];
    logic [2:0]  busy_v;

    logic [63:0] mm [3][32];
    logic [63:0] m1 [3];
    logic [63:0] m2 [3];
    int          left [3];
    logic        chk_en = 0;
    int          total = 0, bad = 0;

    always #5 clk = ~clk;

    reg_file_param u0 (.clk(clk), .reset(reset), .ren1(ren1), .raddr1(raddr1), .rdata1(rd1[0]),
        .ren2(ren2), .raddr2(raddr2), .rdata2(rd2[0]), .wen(wen), .waddr(waddr), .wdata(wdata), .busy(busy_v[0]));
    reg_file_param #(.ZERO_REG(0)) u1 (.clk(clk), .reset(reset), .ren1(ren1), .raddr1(raddr1), .rdata1(rd1[1]),
        .ren2(ren2), .raddr2(raddr2), .rdata2(rd2[1]), .wen(wen), .waddr(waddr), .wdata(wdata), .busy(busy_v[1]));
    reg_file_param #(.DEPTH(20)) u2 (.clk(clk), .reset(reset), .ren1(ren1), .raddr1(raddr1), .rdata1(rd1[2]),
        .ren2(ren2), .raddr2(raddr2), .rdata2(rd2[2]), .wen(wen), .waddr(waddr), .wdata(wdata), .busy(busy_v[2]));

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%h want=%h t=%0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [63:0] rv(input int i, input logic [4:0] a);
        if (int'(a) >= DEP[i] || (ZR[i] != 0 && a == 0)) return 64'h0;
`ifdef REGFILE_BYPASS_EN
        if (wen && waddr == a) return wdata;
`endif
        return mm[i][a];
    endfunction

    always @(posedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (reset) begin
                left[i] <= DEP[i];
                m1[i] <= 0;
                m2[i] <= 0;
                for (int a = 0; a < 32; a++) mm[i][a] <= 0;
            end else if (left[i] != 0) begin
                left[i] <= left[i] - 1;
            end else begin
                if (ren1) m1[i] <= rv(i, raddr1);
                if (ren2) m2[i] <= rv(i, raddr2);
                if (wen && int'(waddr) < DEP[i] && !(ZR[i] != 0 && waddr == 0)) mm[i][waddr] <= wdata;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            for (int i = 0; i < 3; i++) begin
                check($sformatf("busy%0d", i), 64'(busy_v[i]), 64'(left[i] != 0));
                check($sformatf("rdata1_%0d", i), rd1[i], m1[i]);
                check($sformatf("rdata2_%0d", i), rd2[i], m2[i]);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic idle();
        wen = 0; ren1 = 0; ren2 = 0;
    endtask

    task automatic wr(input logic [4:0] a, input logic [63:0] d);
        idle(); wen = 1; waddr = a; wdata = d; tick(1); wen = 0;
    endtask

    task automatic rd(input logic [4:0] a1, input logic [4:0] a2);
        idle(); ren1 = 1; raddr1 = a1; ren2 = 1; raddr2 = a2; tick(1); idle();
    endtask

    task automatic busy_len(input string nm, input int want);
        int n = 0;
        while (busy_v[0] && n < 100) begin
            tick(1);
            n++;
        end
        check(nm, 64'(n), 64'(want));
    endtask

    initial begin
        tick(1);
        chk_en = 1;
        check("reset_busy", 64'(busy_v), 64'h7);
        check("reset_rdata", rd1[0], 64'h0);
        tick(1);
        reset = 0;
        busy_len("busy_after_reset", 32);
        check("d20_ready", 64'(busy_v[2]), 64'h0);
        for (int a = 0; a < 32; a++) rd(5'(a), 5'(31 - a));
        check("cleared_read", rd1[0], 64'h0);

        wr(5, 64'hDEADBEEF_00000001);
        idle(); ren1 = 1; raddr1 = 5; tick(1);
        idle(); ren2 = 1; raddr2 = 5; tick(1); idle();
        check("p1_addr5", rd1[0], 64'hDEADBEEF_00000001);
        check("p2_addr5", rd2[0], 64'hDEADBEEF_00000001);
        check("model_addr5", m2[0], 64'hDEADBEEF_00000001);

        wr(0, 64'h1234);
        rd(0, 0);
        check("zr1_addr0", rd1[0], 64'h0);
        check("zr0_addr0", rd1[1], 64'h1234);
        check("model_zr0", m1[1], 64'h1234);

        wr(7, 64'hAA);
        idle(); wen = 1; waddr = 7; wdata = 64'hBB; ren1 = 1; raddr1 = 7; tick(1); idle();
`ifdef REGFILE_BYPASS_EN
        check("same_edge_rw", rd1[0], 64'hBB);
`else
        check("same_edge_rw", rd1[0], 64'hAA);
`endif
        rd(7, 7);
        check("after_rw", rd1[0], 64'hBB);
        idle(); wen = 1; waddr = 0; wdata = 64'h77; ren2 = 1; raddr2 = 0; tick(1); idle();
        check("same_edge_zr", rd2[0], 64'h0);

        wr(25, 64'h55);
        rd(25, 25);
        check("d20_oob", rd1[2], 64'h0);
        check("d32_addr25", rd1[0], 64'h55);
        wr(19, 64'h99);
        rd(19, 19);
        check("d20_addr19", rd2[2], 64'h99);
        for (int a = 1; a <= 8; a++) wr(5'(a + 8), 64'(a) * 64'h1111_0000_1111);
        for (int a = 1; a <= 8; a++) rd(5'(a + 8), 5'(17 - a));
        check("pattern_p1", rd1[0], 64'h8888_0000_8888);

        reset = 1; tick(1); reset = 0;
        tick(10);
        reset = 1; wen = 1; waddr = 3; wdata = 64'hFF; ren1 = 1; raddr1 = 5; tick(1);
        reset = 0;
        busy_len("busy_mid_restart", 32);
        idle();
        rd(3, 5);
        check("lost_write", rd1[0], 64'h0);
        check("cleared_addr5", rd2[0], 64'h0);
        tick(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

endmodule
